fxp2fp32_conv: RTL and testbench
================================

// Module: fxp2fp32_conv
// PURPOSE
//  Streaming converter: signed fixed-point word (C_ARITH_WORD_LEN, Q INT.FRAC) -> IEEE-754 binary32 bit pattern.
//  Synthesizable inverse of the package real->fxp path; exports CNN layer results to fp32 consumers (host DMA, debug taps).
//  3-stage elastic pipeline, valid/ready on both sides; conversion is exact for all legal configs.
// PARAMETERS
//  C_WORD_WDT   C_ARITH_WORD_LEN (18)     input word width, two's complement; legal range 2..25 (exactness limit)
//  C_FRAC_WDT   C_ARITH_FXP_FRAC_WDT (10) fractional bits of input; 0..C_WORD_WDT-1
// PORTS
//  clk          in   1            clock, rising edge
//  rst_n        in   1            asynchronous reset, active low
//  in_vld       in   1            input word valid
//  in_rdy       out  1            converter accepts input this cycle
//  in_data      in   C_WORD_WDT   fixed-point operand
//  in_last      in   1            end-of-tile marker, passed through aligned with data
//  out_vld      out  1            output word valid
//  out_rdy      in   1            downstream accepts output this cycle
//  out_data     out  32           binary32 {sign, exp[7:0], mant[22:0]}
//  out_last     out  1            in_last delayed with its word
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valids, out_vld, out_data, out_last = 0; in_rdy = 1 after reset.
//  - Transfer on a side when vld & rdy in the same cycle. Latency 3 cycles in->out with out_rdy held 1; throughput 1/cycle.
//  - Stage n loads when empty or stage n+1 loads (stage 3: empty or out_rdy); in_rdy = stage-1 load condition.
//    Ready path is combinational back through the stages; no word dropped/duplicated under any out_rdy pattern.
//  - out_vld, out_data, out_last stable while out_vld & !out_rdy.
//  - S1: sign = in_data[MSB]; mag = |in_data| as C_WORD_WDT-bit unsigned (min-neg -> 2^(C_WORD_WDT-1), no overflow).
//  - S2: p = index of highest set bit of mag (priority/LZC); norm = mag << (C_WORD_WDT-1-p); zero flag = (mag==0).
//  - S3: exp = p - C_FRAC_WDT + 127 (8 bits, always in 1..254 for legal params); mant = norm bits below hidden 1,
//    left-aligned into 23 bits, zero-padded. No rounding needed (<=24 significant bits).
//  - Zero input -> 0x0000_0000 (+0.0, never -0.0). No denormals/Inf/NaN are producible.
//  - in_last follows its word through every stage unchanged.
//  - Reset mid-stream: in-flight words discarded, no partial output after release.
//  - Elaboration: $error if C_WORD_WDT>25 or C_FRAC_WDT>=C_WORD_WDT.
// STRUCTURE
//  - Shared package arith_pckg gains: C_FP32_EXP_BIAS=127, C_FP32_EXP_WDT=8, C_FP32_MANT_WDT=23,
//    typedef struct packed {logic sign; logic [7:0] exp; logic [22:0] mant;} fp32_t; out_data is fp32_t-packed.
//  - One sub-module: arith_lzc (parameterized width, combinational leading-zero count + all-zero flag), used in S2.
//  - Stage registers and handshake in this module; no memories.
// TESTING (C_WORD_WDT=18, C_FRAC_WDT=10 unless stated)
//  1 Basic values, out_rdy=1: 0x00400(+1.0)->0x3F800000; 0x3FC00(-1.0)->0xBF800000; 0x00001->0x3A800000;
//    0x00000->0x00000000; each appears exactly 3 cycles after accept.
//  2 Extremes: 0x1FFFF->0x42FFFF80; 0x20000(-128.0)->0xC3000000; 0x3FFFF(-2^-10)->0xBA800000.
//  3 Backpressure: 100 random words, in_vld/out_rdy random 50%; output sequence == reference model in order,
//    out_data/out_last held stable while stalled, no loss/duplication; in_rdy=0 only when all 3 stages full & !out_rdy.
//  4 Last tagging: burst of 16 words, in_last on word 16 -> out_last high only with 16th output.
//  5 Reset mid-stream: rst_n low with 3 words in flight -> out_vld=0 immediately; after release first output
//    is the first word accepted post-reset.
//  6 Exhaustive: all 2^18 inputs vs real-model ($bitstoshortreal(out)==in*2^-10 exactly); repeat with C_FRAC_WDT=0, 17.

Source files
------------

// File: rtl/arith_pckg.sv
// rtl/arith_pckg.sv - shared fixed-point arithmetic constants and fp32 packing types
package arith_pckg;

    localparam int C_ARITH_WORD_LEN     = 18;
    localparam int C_ARITH_FXP_FRAC_WDT = 10;

    localparam int C_FP32_EXP_BIAS = 127;
    localparam int C_FP32_EXP_WDT  = 8;
    localparam int C_FP32_MANT_WDT = 23;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } fp32_t;

endpackage

// File: rtl/arith_lzc.sv
// rtl/arith_lzc.sv - combinational leading-zero count with all-zero flag
module arith_lzc #(
    parameter int WDT     = 18,
    parameter int CNT_WDT = $clog2(WDT + 1)
) (
    input  logic [WDT-1:0]     din,
    output logic [CNT_WDT-1:0] cnt,
    output logic               zero
);

    // Ascending scan so the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = CNT_WDT'(WDT);
        for (int i = 0; i < WDT; i++) begin
            if (din[i]) begin
                cnt = CNT_WDT'(WDT - 1 - i);
            end
        end
    end

    assign zero = (din == '0);

endmodule

// File: rtl/fxp2fp32_conv.sv
// rtl/fxp2fp32_conv.sv - 3-stage elastic signed fixed-point to binary32 converter
module fxp2fp32_conv
    import arith_pckg::*;
#(
    parameter int C_WORD_WDT = C_ARITH_WORD_LEN,
    parameter int C_FRAC_WDT = C_ARITH_FXP_FRAC_WDT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [C_WORD_WDT-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [31:0]           out_data,
    output logic                  out_last
);

    localparam int CNT_WDT = $clog2(C_WORD_WDT + 1);
    // Exponent of a word whose top bit is set; each leading zero lowers it by one.
    localparam int EXP_TOP = C_WORD_WDT - 1 - C_FRAC_WDT + C_FP32_EXP_BIAS;

    generate
        if (C_WORD_WDT > 25 || C_WORD_WDT < 2 || C_FRAC_WDT < 0 || C_FRAC_WDT >= C_WORD_WDT) begin : g_param_check
            $error("fxp2fp32_conv: illegal C_WORD_WDT/C_FRAC_WDT combination");
        end
    endgenerate

    logic load1, load2, load3;

    logic                  s1_vld, s1_sign, s1_last;
    logic [C_WORD_WDT-1:0] s1_mag;
    logic [C_WORD_WDT-1:0] mag_c;

    logic                  s2_vld, s2_sign, s2_zero, s2_last;
    logic [CNT_WDT-1:0]    s2_cnt;
    logic [C_WORD_WDT-2:0] s2_norm;
    logic [CNT_WDT-1:0]    lzc_cnt;
    logic                  lzc_zero;

    fp32_t res_c;

    assign load3  = !out_vld || out_rdy;
    assign load2  = !s2_vld || load3;
    assign load1  = !s1_vld || load2;
    assign in_rdy = load1;

    // Min-negative wraps to 2^(W-1), which is exactly its magnitude as unsigned.
    assign mag_c = in_data[C_WORD_WDT-1] ? (~in_data + C_WORD_WDT'(1)) : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_mag  <= '0;
            s1_last <= 1'b0;
        end else if (load1) begin
            s1_vld <= in_vld;
            if (in_vld) begin
                s1_sign <= in_data[C_WORD_WDT-1];
                s1_mag  <= mag_c;
                s1_last <= in_last;
            end
        end
    end

    arith_lzc #(
        .WDT     (C_WORD_WDT),
        .CNT_WDT (CNT_WDT)
    ) u_lzc (
        .din  (s1_mag),
        .cnt  (lzc_cnt),
        .zero (lzc_zero)
    );

    // The hidden 1 is implicit after normalisation, so only the bits below it are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld  <= 1'b0;
            s2_sign <= 1'b0;
            s2_zero <= 1'b0;
            s2_cnt  <= '0;
            s2_norm <= '0;
            s2_last <= 1'b0;
        end else if (load2) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_sign <= s1_sign;
                s2_zero <= lzc_zero;
                s2_cnt  <= lzc_cnt;
                s2_norm <= (C_WORD_WDT-1)'(s1_mag << lzc_cnt);
                s2_last <= s1_last;
            end
        end
    end

    always_comb begin
        res_c = '0;
        if (!s2_zero) begin
            res_c.sign = s2_sign;
            res_c.exp  = 8'(EXP_TOP) - 8'(s2_cnt);
            res_c.mant = C_FP32_MANT_WDT'({s2_norm, 23'b0} >> (C_WORD_WDT - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_last <= 1'b0;
        end else if (load3) begin
            out_vld <= s2_vld;
            if (s2_vld) begin
                out_data <= res_c;
                out_last <= s2_last;
            end
        end
    end

endmodule

// File: tb/tb_fxp2fp32_conv.sv
// tb/tb_fxp2fp32_conv.sv - directed and backpressure bench for fxp2fp32_conv
module tb_fxp2fp32_conv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [17:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    fxp2fp32_conv dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last)
    );

    typedef struct {
        logic [17:0] din;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    exp_t        q[$];
    logic [31:0] drv_exp = '0;
    bit          rand_rdy = 1'b0;
    bit          hold_pend = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    vec_t        vecs[11];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(logic [17:0] d);
        int          v;
        real         r;
        logic [63:0] b;
        int          e;
        if (d == '0) return 32'h0;
        v = int'($signed(d));
        r = real'(v) / 1024.0;
        b = $realtobits(r);
        e = int'(b[62:52]) - 1023 + 127;
        return {b[63], 8'(e), b[51:29]};
    endfunction

    task automatic step(output bit fi);
        exp_t e;
        if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
        @(negedge clk);
        fi = in_vld && in_rdy;
        if (hold_pend) begin
            chk("hold_vld", 32'(out_vld), 32'd1);
            chk("hold_data", out_data, held_data);
            chk("hold_last", 32'(out_last), 32'(held_last));
        end
        hold_pend = out_vld && !out_rdy;
        held_data = out_data;
        held_last = out_last;
        chk("in_rdy_rule", 32'(in_rdy), 32'(!(q.size() == 3 && !out_rdy)));
        if (out_vld && out_rdy) begin
            chk("out_expected", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
        if (fi) q.push_back('{drv_exp, in_last});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(int n);
        bit f;
        in_vld = 1'b0;
        repeat (n) step(f);
    endtask

    task automatic send(logic [17:0] d, logic l, logic [31:0] e);
        bit f;
        int guard;
        guard   = 0;
        in_vld  = 1'b1;
        in_data = d;
        in_last = l;
        drv_exp = e;
        do begin
            step(f);
            guard++;
        end while (!f && guard < 200);
        chk("accept_timeout", 32'(f), 32'd1);
        in_vld  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        bit f;
        int guard;
        guard    = 0;
        rand_rdy = 1'b0;
        out_rdy  = 1'b1;
        in_vld   = 1'b0;
        while (q.size() != 0 && guard < 200) begin
            step(f);
            guard++;
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (4) step(f);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        logic [17:0] d;
        logic        l;

        vecs[0]  = '{18'h00400, 32'h3F80_0000};
        vecs[1]  = '{18'h3FC00, 32'hBF80_0000};
        vecs[2]  = '{18'h00001, 32'h3A80_0000};
        vecs[3]  = '{18'h00000, 32'h0000_0000};
        vecs[4]  = '{18'h1FFFF, 32'h42FF_FF80};
        vecs[5]  = '{18'h20000, 32'hC300_0000};
        vecs[6]  = '{18'h3FFFF, 32'hBA80_0000};
        vecs[7]  = '{18'h00C00, 32'h4040_0000};
        vecs[8]  = '{18'h00200, 32'h3F00_0000};
        vecs[9]  = '{18'h3F600, 32'hC020_0000};
        vecs[10] = '{18'h0A000, 32'h4220_0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_vld", 32'(out_vld), 32'd0);

        // Latency: output register fills on the third edge counting the accept edge.
        out_rdy = 1'b1;
        send(vecs[0].din, 1'b0, vecs[0].exp);
        chk("lat_edge1", 32'(out_vld), 32'd0);
        idle(1);
        chk("lat_edge2", 32'(out_vld), 32'd0);
        idle(1);
        chk("lat_edge3_vld", 32'(out_vld), 32'd1);
        chk("lat_edge3_data", out_data, vecs[0].exp);

        c0 = cyc;
        for (int i = 1; i < 11; i++) send(vecs[i].din, 1'b0, vecs[i].exp);
        chk("throughput_cycles", 32'(cyc - c0), 32'd10);
        drain();

        for (int k = 1; k <= 16; k++) begin
            d = 18'(k * 4099);
            send(d, k == 16, model(d));
        end
        drain();

        rand_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if ($urandom_range(0, 1) == 1) idle(1);
            d = 18'($urandom);
            l = ($urandom_range(0, 7) == 0);
            send(d, l, model(d));
        end
        drain();

        out_rdy = 1'b0;
        send(18'h00400, 1'b0, 32'h3F80_0000);
        send(18'h3FC00, 1'b0, 32'hBF80_0000);
        send(18'h00001, 1'b1, 32'h3A80_0000);
        chk("stall_in_rdy", 32'(in_rdy), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_vld", 32'(out_vld), 32'd0);
        chk("midrst_out_data", out_data, 32'd0);
        chk("midrst_in_rdy", 32'(in_rdy), 32'd1);
        q.delete();
        hold_pend = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_rdy = 1'b1;
        send(18'h00C00, 1'b1, 32'h4040_0000);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
